// File: rtl/ldpc_min_pkg.sv
// Shared types and magnitude helpers for the min-sum check-node stages.
// Used by the minimum scheduler and by the check-to-variable update stage.
package ldpc_min_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Largest representable magnitude of a signed message of 'bits' bits.
    function automatic int maxmag(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    // |x| with the most negative code folded onto maxmag.
    function automatic int sat_abs(input int x, input int bits);
        if (x == -(1 << (bits - 1)))
            return maxmag(bits);
        else if (x < 0)
            return -x;
        else
            return x;
    endfunction

endpackage

// File: rtl/cnu_min_sched_fmig2k.sv
// FMIG2k: combinational 2**K-input signed minimum tree returning value and lane.
// On equal operands the higher lane wins at every level.
module fmig2k #(
    parameter int BITS = 8,
    parameter int K    = 3
) (
    input  logic [2**K-1:0][BITS-1:0] in_val,
    output logic [BITS-1:0]           min_val,
    output logic [K-1:0]              min_idx
);

    localparam int W = 2**K;

    logic [W-1:0][BITS-1:0] v;
    logic [W-1:0][K-1:0]    ix;

    // In-place pairwise reduction: node j of a level reads nodes 2j/2j+1 of the previous one.
    always_comb begin
        v = in_val;
        for (int i = 0; i < W; i++) ix[i] = K'(i);
        for (int l = 0; l < K; l++) begin
            for (int j = 0; j < (W >> (l + 1)); j++) begin
                if ($signed(v[2*j+1]) <= $signed(v[2*j])) begin
                    v[j]  = v[2*j+1];
                    ix[j] = ix[2*j+1];
                end else begin
                    v[j]  = v[2*j];
                    ix[j] = ix[2*j];
                end
            end
        end
        min_val = v[0];
        min_idx = ix[0];
    end

endmodule

// File: rtl/cnu_min_sched.sv
// Sequential check-node minimum scheduler: two passes of one shared min tree per beat,
// accumulating min1/min2/index/sign of a row and presenting it over valid/ready.
module cnu_min_sched
    import ldpc_min_pkg::*;
#(
    parameter int  BITS  = 8,
    parameter int  K     = 3,
    parameter int  BEATS = 4,
    localparam int W     = 2**K,
    localparam int BCW   = $clog2(BEATS),
    localparam int IB    = K + BCW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0][BITS-1:0] in_data,
    input  logic [W-1:0]           in_mask,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BITS-2:0]        out_min1,
    output logic [BITS-2:0]        out_min2,
    output logic [IB-1:0]          out_idx,
    output logic                   out_sign
);

    localparam logic [BITS-2:0] MAXMAG = (BITS-1)'(maxmag(BITS));

    state_t                 state_q, state_d;
    logic [W-1:0][BITS-1:0] data_q, data_d;
    logic [W-1:0]           mask_q, mask_d;
    logic                   last_q, last_d;
    logic [BCW-1:0]         bc_q, bc_d;
    logic [BITS-2:0]        c1_q, c1_d;
    logic [K-1:0]           cl_q, cl_d;
    logic [BITS-2:0]        acc1_q, acc1_d;
    logic [BITS-2:0]        acc2_q, acc2_d;
    logic [IB-1:0]          accidx_q, accidx_d;
    logic                   accsign_q, accsign_d;
    logic [BITS-2:0]        out_min1_q, out_min1_d;
    logic [BITS-2:0]        out_min2_q, out_min2_d;
    logic [IB-1:0]          out_idx_q, out_idx_d;
    logic                   out_sign_q, out_sign_d;

    logic [W-1:0][BITS-2:0] mag;
    logic [W-1:0][BITS-1:0] tree_in;
    logic [BITS-1:0]        tree_min;
    logic [K-1:0]           tree_idx;
    logic [BITS-2:0]        chunk_min;
    logic                   row_sign;

    // Masked lanes present MAXMAG so they never win; their sign does not count.
    always_comb begin
        row_sign = 1'b0;
        for (int i = 0; i < W; i++) begin
            mag[i]   = mask_q[i] ? (BITS-1)'(sat_abs(int'($signed(data_q[i])), BITS)) : MAXMAG;
            row_sign = row_sign ^ (data_q[i][BITS-1] & mask_q[i]);
        end
    end

    // Second pass knocks out the first-pass winner to expose the chunk's second minimum.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            tree_in[i] = {1'b0, ((state_q == P2) && (K'(i) == cl_q)) ? MAXMAG : mag[i]};
        end
    end

    fmig2k #(
        .BITS (BITS),
        .K    (K)
    ) u_tree (
        .in_val  (tree_in),
        .min_val (tree_min),
        .min_idx (tree_idx)
    );

    // Operands are non-negative; a set MSB cannot occur but saturates rather than wraps.
    assign chunk_min = tree_min[BITS-1] ? MAXMAG : tree_min[BITS-2:0];

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        mask_d     = mask_q;
        last_d     = last_q;
        bc_d       = bc_q;
        c1_d       = c1_q;
        cl_d       = cl_q;
        acc1_d     = acc1_q;
        acc2_d     = acc2_q;
        accidx_d   = accidx_q;
        accsign_d  = accsign_q;
        out_min1_d = out_min1_q;
        out_min2_d = out_min2_q;
        out_idx_d  = out_idx_q;
        out_sign_d = out_sign_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    mask_d  = in_mask;
                    last_d  = in_last;
                    state_d = P1;
                    if (bc_q == '0) begin
                        acc1_d    = MAXMAG;
                        acc2_d    = MAXMAG;
                        accidx_d  = '0;
                        accsign_d = 1'b0;
                    end
                end
            end
            P1: begin
                c1_d    = chunk_min;
                cl_d    = tree_idx;
                state_d = P2;
            end
            P2: begin
                // Strict compare keeps the earlier beat on cross-beat ties.
                if (c1_q < acc1_q) begin
                    acc2_d   = (acc1_q < chunk_min) ? acc1_q : chunk_min;
                    acc1_d   = c1_q;
                    accidx_d = {bc_q, cl_q};
                end else begin
                    acc2_d   = (acc2_q < c1_q) ? acc2_q : c1_q;
                end
                accsign_d = accsign_q ^ row_sign;
                if (last_q || (bc_q == BCW'(BEATS - 1))) begin
                    bc_d       = '0;
                    state_d    = OUT;
                    out_min1_d = acc1_d;
                    out_min2_d = acc2_d;
                    out_idx_d  = accidx_d;
                    out_sign_d = accsign_d;
                end else begin
                    bc_d    = bc_q + 1'b1;
                    state_d = IDLE;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
            bc_q       <= '0;
            c1_q       <= '0;
            cl_q       <= '0;
            acc1_q     <= MAXMAG;
            acc2_q     <= MAXMAG;
            accidx_q   <= '0;
            accsign_q  <= 1'b0;
            out_min1_q <= '0;
            out_min2_q <= '0;
            out_idx_q  <= '0;
            out_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            bc_q       <= bc_d;
            c1_q       <= c1_d;
            cl_q       <= cl_d;
            acc1_q     <= acc1_d;
            acc2_q     <= acc2_d;
            accidx_q   <= accidx_d;
            accsign_q  <= accsign_d;
            out_min1_q <= out_min1_d;
            out_min2_q <= out_min2_d;
            out_idx_q  <= out_idx_d;
            out_sign_q <= out_sign_d;
        end
    end

    assign out_min1 = out_min1_q;
    assign out_min2 = out_min2_q;
    assign out_idx  = out_idx_q;
    assign out_sign = out_sign_q;

endmodule

// File: tb/tb_cnu_min_sched.sv
// Self-checking bench for cnu_min_sched: directed rows, random rows against a
// whole-row reference model, handshake timing, output hold and mid-row reset.
module tb_cnu_min_sched;

    localparam int BITS  = 8;
    localparam int K     = 3;
    localparam int BEATS = 4;
    localparam int W     = 8;
    localparam int IB    = 5;
    localparam int MAXM  = 127;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0][BITS-1:0] in_data;
    logic [W-1:0]           in_mask;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [BITS-2:0]        out_min1;
    logic [BITS-2:0]        out_min2;
    logic [IB-1:0]          out_idx;
    logic                   out_sign;

    cnu_min_sched #(.BITS(BITS), .K(K), .BEATS(BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min1  (out_min1),
        .out_min2  (out_min2),
        .out_idx   (out_idx),
        .out_sign  (out_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Current row: signed lane values, masks, beat count, whether in_last is used.
    int rv [BEATS][W];
    bit rm [BEATS][W];
    int rn;
    bit ruse_last;

    // Results captured by finish_row.
    int g_min1, g_min2, g_idx, g_sign, g_lat;
    bit g_ok;

    function automatic void model(output int m1, output int m2, output int idx, output int s);
        int vals[$];
        int mg [BEATS][W];
        bit found;
        s = 0;
        idx = 0;
        for (int b = 0; b < rn; b++) begin
            for (int l = 0; l < W; l++) begin
                if (!rm[b][l]) mg[b][l] = MAXM;
                else if (rv[b][l] == -128) mg[b][l] = MAXM;
                else if (rv[b][l] < 0) mg[b][l] = -rv[b][l];
                else mg[b][l] = rv[b][l];
                vals.push_back(mg[b][l]);
                if (rm[b][l] && rv[b][l] < 0) s = s ^ 1;
            end
        end
        vals.sort();
        m1 = vals[0];
        m2 = vals[1];
        found = 0;
        if (m1 < MAXM) begin
            for (int b = 0; b < rn; b++) begin
                for (int l = W - 1; l >= 0; l--) begin
                    if (!found && mg[b][l] == m1) begin
                        idx = b * W + l;
                        found = 1;
                    end
                end
            end
        end
    endfunction

    task automatic send_beat(input int b, input bit last, output bit ok);
        ok = 0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                for (int l = 0; l < W; l++) begin
                    in_data[l] = BITS'(rv[b][l]);
                    in_mask[l] = rm[b][l];
                end
                in_last  = last;
                in_valid = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = {$urandom, $urandom};
                in_mask  = W'($urandom);
                ok = 1;
            end
        end
    endtask

    task automatic finish_row(input bit pop);
        bit seen;
        seen  = 0;
        g_lat = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            g_lat++;
            if (out_valid) seen = 1;
        end
        if (!seen) g_ok = 0;
        g_min1 = out_min1;
        g_min2 = out_min2;
        g_idx  = out_idx;
        g_sign = out_sign;
        if (pop && seen) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic run_row(input bit pop);
        bit ok;
        g_ok = 1;
        for (int b = 0; b < rn; b++) begin
            send_beat(b, ruse_last && (b == rn - 1), ok);
            if (!ok) g_ok = 0;
        end
        finish_row(pop);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %0b want 0", out_valid); end
        n_chk++; if (out_min1 !== '0 || out_min2 !== '0) begin n_fail++; $display("FAIL reset_mins: got %0d/%0d want 0/0", out_min1, out_min2); end
        n_chk++; if (out_idx !== '0 || out_sign !== 1'b0) begin n_fail++; $display("FAIL reset_idx_sign: got %0d/%0b want 0/0", out_idx, out_sign); end
    endtask

    task automatic test_directed();
        int e1[5] = '{2, 4, 1, 127, 0};
        int e2[5] = '{3, 4, 1, 127, 50};
        int ei[5] = '{3, 7, 13, 0, 24};
        int es[5] = '{0, 0, 1, 1, 0};
        for (int t = 0; t < 5; t++) begin
            for (int b = 0; b < BEATS; b++)
                for (int l = 0; l < W; l++) begin
                    rv[b][l] = 0;
                    rm[b][l] = 1;
                end
            ruse_last = 1;
            case (t)
                0: begin rn = 1; rv[0] = '{5, -3, 7, 2, -9, 4, 6, 8}; end
                1: begin rn = 1; for (int l = 0; l < W; l++) rv[0][l] = -4; end
                2: begin
                    rn = 2;
                    for (int l = 0; l < W; l++) begin rv[0][l] = 10; rv[1][l] = 20; end
                    rv[1][2] = 1;
                    rv[1][5] = -1;
                end
                3: begin
                    rn = 1;
                    for (int l = 0; l < W; l++) begin rv[0][l] = -(l + 1); rm[0][l] = (l == 0); end
                    rv[0][0] = -128;
                end
                default: begin
                    rn = 4;
                    ruse_last = 0;
                    for (int b = 0; b < BEATS; b++)
                        for (int l = 0; l < W; l++) rv[b][l] = 50;
                    rv[3][0] = 0;
                end
            endcase
            run_row(1);
            n_chk++; if (!g_ok) begin n_fail++; $display("FAIL dir%0d_handshake: timeout", t); end
            n_chk++; if (g_lat !== 3) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 3", t, g_lat); end
            n_chk++; if (g_min1 !== e1[t]) begin n_fail++; $display("FAIL dir%0d_min1: got %0d want %0d", t, g_min1, e1[t]); end
            n_chk++; if (g_min2 !== e2[t]) begin n_fail++; $display("FAIL dir%0d_min2: got %0d want %0d", t, g_min2, e2[t]); end
            n_chk++; if (g_idx !== ei[t]) begin n_fail++; $display("FAIL dir%0d_idx: got %0d want %0d", t, g_idx, ei[t]); end
            n_chk++; if (g_sign !== es[t]) begin n_fail++; $display("FAIL dir%0d_sign: got %0d want %0d", t, g_sign, es[t]); end
        end
    endtask

    task automatic randomize_row();
        int mode;
        rn = $urandom_range(1, BEATS);
        ruse_last = (rn < BEATS) ? 1'b1 : 1'(($urandom_range(0, 1)));
        for (int b = 0; b < BEATS; b++) begin
            mode = $urandom_range(0, 3);
            for (int l = 0; l < W; l++) begin
                if (mode == 0) rv[b][l] = int'($urandom_range(0, 255)) - 128;
                else if (mode == 1) rv[b][l] = int'($urandom_range(0, 6)) - 3;
                else if (mode == 2) rv[b][l] = ($urandom_range(0, 3) == 0) ? -128 : int'($urandom_range(0, 20)) - 10;
                else rv[b][l] = int'($urandom_range(0, 40));
                rm[b][l] = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            end
            if ($urandom_range(0, 7) == 0)
                for (int l = 0; l < W; l++) rm[b][l] = 1'b0;
        end
    endtask

    task automatic test_random();
        int e1, e2, ei, es;
        for (int t = 0; t < 60; t++) begin
            randomize_row();
            model(e1, e2, ei, es);
            run_row(1);
            n_chk++; if (!g_ok) begin n_fail++; $display("FAIL rnd%0d_handshake: timeout", t); end
            n_chk++; if (g_lat !== 3) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want 3", t, g_lat); end
            n_chk++; if (g_min1 !== e1) begin n_fail++; $display("FAIL rnd%0d_min1: got %0d want %0d", t, g_min1, e1); end
            n_chk++; if (g_min2 !== e2) begin n_fail++; $display("FAIL rnd%0d_min2: got %0d want %0d", t, g_min2, e2); end
            n_chk++; if (g_idx !== ei) begin n_fail++; $display("FAIL rnd%0d_idx: got %0d want %0d", t, g_idx, ei); end
            n_chk++; if (g_sign !== es) begin n_fail++; $display("FAIL rnd%0d_sign: got %0d want %0d", t, g_sign, es); end
        end
    endtask

    task automatic test_back_to_back();
        int e1, e2, ei, es;
        bit ok;
        randomize_row();
        rn = 2;
        ruse_last = 1;
        model(e1, e2, ei, es);
        g_ok = 1;
        send_beat(0, 1'b0, ok);
        if (!ok) g_ok = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (in_ready !== (c == 3)) begin
                n_fail++;
                $display("FAIL b2b_in_ready_c%0d: got %0b want %0b", c, in_ready, (c == 3));
            end
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_out_valid_c%0d: got %0b want 0", c, out_valid); end
        end
        send_beat(1, 1'b1, ok);
        if (!ok) g_ok = 0;
        finish_row(1);
        n_chk++; if (!g_ok) begin n_fail++; $display("FAIL b2b_handshake: timeout"); end
        n_chk++; if (g_min1 !== e1 || g_min2 !== e2) begin n_fail++; $display("FAIL b2b_mins: got %0d/%0d want %0d/%0d", g_min1, g_min2, e1, e2); end
        n_chk++; if (g_idx !== ei || g_sign !== es) begin n_fail++; $display("FAIL b2b_idx_sign: got %0d/%0d want %0d/%0d", g_idx, g_sign, ei, es); end
    endtask

    task automatic test_hold();
        int e1, e2, ei, es;
        randomize_row();
        model(e1, e2, ei, es);
        run_row(0);
        n_chk++; if (!g_ok) begin n_fail++; $display("FAIL hold_handshake: timeout"); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = '0;
            in_mask  = '1;
            @(negedge clk);
            n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d_flags: got v=%0b r=%0b want v=1 r=0", c, out_valid, in_ready); end
            n_chk++; if (out_min1 !== e1 || out_min2 !== e2) begin n_fail++; $display("FAIL hold%0d_mins: got %0d/%0d want %0d/%0d", c, out_min1, out_min2, e1, e2); end
            n_chk++; if (out_idx !== ei || out_sign !== es) begin n_fail++; $display("FAIL hold%0d_idx_sign: got %0d/%0b want %0d/%0d", c, out_idx, out_sign, ei, es); end
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got r=%0b v=%0b want r=1 v=0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid();
        int e1, e2, ei, es;
        bit ok;
        rn = 1;
        ruse_last = 0;
        for (int l = 0; l < W; l++) begin rv[0][l] = 3; rm[0][l] = 1; end
        send_beat(0, 1'b0, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rstmid_accept: timeout"); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (out_min1 !== '0 || out_min2 !== '0) begin n_fail++; $display("FAIL rstmid_mins: got %0d/%0d want 0/0", out_min1, out_min2); end
        n_chk++; if (out_idx !== '0 || out_sign !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idx_sign_valid: got %0d/%0b/%0b want 0/0/0", out_idx, out_sign, out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
        rn = 1;
        ruse_last = 1;
        for (int l = 0; l < W; l++) begin rv[0][l] = 40; rm[0][l] = 1; end
        rv[0][2] = 9;
        rv[0][5] = -20;
        model(e1, e2, ei, es);
        run_row(1);
        n_chk++; if (!g_ok) begin n_fail++; $display("FAIL rstmid_row_handshake: timeout"); end
        n_chk++; if (g_min1 !== e1 || g_min2 !== e2) begin n_fail++; $display("FAIL rstmid_row_mins: got %0d/%0d want %0d/%0d", g_min1, g_min2, e1, e2); end
        n_chk++; if (g_idx !== ei || g_sign !== es) begin n_fail++; $display("FAIL rstmid_row_idx_sign: got %0d/%0d want %0d/%0d", g_idx, g_sign, ei, es); end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cnu_min_sched.md
# cnu_min_sched

Sequential check-node minimum scheduler for the min-sum LDPC decoder. It accepts one check-node row of signed variable-to-check messages as up to BEATS beats of W = 2**K lanes and time-shares a single 2**K-input minimum tree across two passes per beat. It accumulates the row's first minimum magnitude, second minimum magnitude, first-minimum index and sign product, then presents them to the check-to-variable update stage over a valid/ready handshake.

## Interface
- BITS, 8: message width, signed two's complement; magnitudes are BITS-1 bits.
- K, 3: lane exponent; W = 2**K lanes per beat.
- BEATS, 4: maximum beats per row; IB = K + $clog2(BEATS) index bits.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  W x BITS  signed messages, lane 0 first.
- in_mask  in  W  1 = lane participates; 0 = lane forced to MAXMAG, sign ignored.
- in_last  in  1  final beat of row.
- out_valid  out  1  row result valid.
- out_ready  in  1  consumer accepts result.
- out_min1  out  BITS-1  smallest magnitude.
- out_min2  out  BITS-1  second smallest magnitude.
- out_idx  out  IB  position of min1: beat*W + lane.
- out_sign  out  1  XOR of signs of unmasked lanes.

## Operation
- Magnitude: |x| saturated; -2**(BITS-1) maps to MAXMAG = 2**(BITS-1)-1. Tree operands are magnitudes zero-extended to BITS, so signed compare is exact.
- Accepted beat registered (data, mask, last); beat counter bc tracks beat number.
- States: IDLE, P1, P2, OUT.
- IDLE: in_ready=1. On accept, go to P1. If bc==0, clear accumulator: acc1=acc2=MAXMAG, accidx=0, accsign=0.
- P1: tree on the beat's magnitudes; latch chunk min c1 and lane cl. Go to P2.
- P2: tree with lane cl forced to MAXMAG; chunk second min c2. Merge:
  - If c1 < acc1 (strict): acc2=min(acc1,c2), acc1=c1, accidx=bc*W+cl.
  - Else: acc2=min(acc2,c1).
  - accsign ^= XOR of masked signs.
  - If last or bc==BEATS-1: bc=0, go to OUT. Else bc++, go to IDLE.
- OUT: out_valid=1; outputs hold. On out_ready, go to IDLE.
- Ties: within a beat, the tree selects the higher lane. Across beats, the earlier beat wins.
- Fully masked row: min1=min2=MAXMAG, idx=0, sign=0. Single unmasked lane: min2=MAXMAG.

## Timing
- Reset: state IDLE, bc=0, accumulator cleared, in_ready=1 after release. out_valid=0, out_min1=out_min2=0, out_idx=0, out_sign=0.
- Throughput: one beat per 3 cycles. Accept at edge t; P1 in cycle t+1; P2 in cycle t+2.
- Non-last beat: in_ready high again in cycle t+3.
- Last beat: out_valid high from cycle t+3. in_ready rises the cycle after the out handshake.
- in_ready=0 in P1, P2 and OUT. Input changes in those states are ignored.
- Output registers change only on entry to OUT. They stay stable under out_ready=0.
- Reset asserted mid-row or mid-OUT: the partial row is discarded and the block returns to reset values asynchronously.

## Structure
- Package ldpc_min_pkg:
  - state enum {IDLE, P1, P2, OUT}.
  - maxmag(BITS) function and saturating abs function.
  - Shared with the check-node update stage.
- One sub-module: the existing shared FMIG2k minimum tree, a single instance with BITS and K passed through. Its operand mux (P1 magnitudes vs P2 masked magnitudes) is in this block.
- Everything else (FSM, bc, accumulator, merge) is flat in cnu_min_sched.

## Test plan
- One beat, last=1, mask=FF, data {5,-3,7,2,-9,4,6,8} -> min1=2, min2=3, idx=3, sign=0; out_valid 3 cycles after accept.
- One beat, all lanes -4, mask=FF, last -> min1=4, min2=4, idx=7, sign=0.
- Two beats: beat0 all 10; beat1 lane2=1, lane5=-1, rest 20, last -> min1=1, min2=1, idx=13, sign=1.
- One beat, lane0=-128, mask=01, last -> min1=127, min2=127, idx=0, sign=1.
- Four beats without in_last, minimum 0 at beat3 lane0, all other lanes 50 -> result after 4th beat: min1=0, min2=50, idx=24.
- Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Pulse rst_n low during P1 of the next row -> all outputs 0, in_ready=1 after release; the next row computes from a cleared accumulator.
